rram_access_sequencer: RTL and testbench
========================================

# rram_access_sequencer

Parametrised address and pulse sequencer for the RRAM macro. It is the next generation of the fixed 32-entry `state_counter`. It generates cache and data-register addresses for four operations: host read-out, cache fill, array program and forming. Each operation has per-operation terminal-count flags and programmable pulse widths. It sits between the host strobe interface (CE/RE/WE_L) and the array drivers.

## Interface
- `ADDR_W`, 5, width of `cache_add` / `register_add`
- `DEPTH`, 32, number of entries swept per operation; 2 ≤ DEPTH ≤ 2^ADDR_W; need not be a power of two
- `CNT_W`, 4, width of the pulse-width counter
- `WRITE_PULSE`, 4, clk cycles `pulse_en` is held per row in PROGRAM; 1 ≤ value < 2^CNT_W
- `FORM_PULSE`, 12, clk cycles `pulse_en` is held per row in FORMING; 1 ≤ value < 2^CNT_W
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  block enable
- `CE`  in  1  chip enable, active low
- `RE`  in  1  host read strobe; one entry is read out per rising edge
- `WE_L`  in  1  host write strobe; one entry is loaded per rising edge
- `re`, `we`, `forming`  in  1 each  operation requests, sampled only in IDLE
- `cache_add`  out  ADDR_W  cache address
- `register_add`  out  ADDR_W  data-register / array row address
- `pulse_en`  out  1  drives the array write/forming pulse
- `busy`  out  1  high in every state except IDLE
- `read_count_flag`, `cache_count_flag`, `write_count_flag`, `forming_count_flag`  out  1 each  one-cycle completion pulses

## Operation
- **States:** IDLE, READ_OUT, CACHE_FILL, PROGRAM, FORMING.
- **Leaving IDLE:** requires `en`=1 and `CE`=0.
  - Request priority is `forming` > `we` > `re`.
  - `forming` → FORMING; `we` → CACHE_FILL; `re` → READ_OUT.
  - Both address counters are cleared on entry.
- **READ_OUT:**
  - Each detected RE rise advances `register_add`.
  - The rise that occurs at `register_add`=DEPTH-1 pulses `read_count_flag`, wraps `register_add` to 0 and returns to IDLE.
- **CACHE_FILL:**
  - Each detected WE_L rise advances `cache_add`.
  - The rise at DEPTH-1 pulses `cache_count_flag`, wraps `cache_add` to 0 and goes to PROGRAM.
- **PROGRAM:**
  - For each row, `pulse_en`=1 for exactly WRITE_PULSE cycles, then 1 gap cycle with `pulse_en`=0.
  - `register_add` and `cache_add` advance together in the gap cycle.
  - After row DEPTH-1's gap: `write_count_flag` pulses, both counters are 0, and the FSM returns to IDLE.
- **FORMING:** identical to PROGRAM, using FORM_PULSE and `forming_count_flag`; `cache_add` stays 0.
- **Abort:** `en`=0 or `CE`=1 in any non-IDLE state.
  - Next cycle: IDLE, both counters 0, `pulse_en`=0, no flag.
  - Abort has priority over a simultaneous strobe or terminal count.
- **Strobes outside their state:** RE rises outside READ_OUT and WE_L rises outside CACHE_FILL are ignored.
- **Width rules:** address increments compare against DEPTH-1 (not the counter's natural overflow), so non-power-of-two DEPTH wraps correctly. The pulse counter counts 0..PULSE-1.

## Timing
- **Reset:** all outputs 0; state IDLE; synchroniser flops 0.
- **Strobe path:** RE/WE_L pass through a 2-flop synchroniser plus an edge-detect flop.
  - The address changes on the 3rd rising clk edge after the strobe rises.
  - Strobes must be stable ≥2 clk cycles high and ≥2 low.
- **IDLE → operation:** state and `busy` update on the first clk edge that samples a valid request.
  - In PROGRAM and FORMING, `pulse_en` rises one cycle after that edge.
- **Flags:** each flag is asserted for exactly one cycle, coincident with the return to IDLE, or with entry to PROGRAM for `cache_count_flag`.
- **PROGRAM duration:** DEPTH·(WRITE_PULSE+1) cycles from the first `pulse_en` to `write_count_flag`. FORMING likewise with FORM_PULSE.
- **Outputs:** all outputs are registered.

## Structure
- **Package `rram_seq_pkg`:**
  - state enum (IDLE, READ_OUT, CACHE_FILL, PROGRAM, FORMING);
  - default constants for DEPTH, WRITE_PULSE and FORM_PULSE.
- **Sub-module `strobe_sync`:** 2-flop synchroniser plus rising-edge detector with async active-high reset. It is instantiated twice, for RE and WE_L.
- **Top level:** FSM, the two address counters and the pulse counter.

## Test plan
- **Reset mid-FORMING** (DEPTH=32, FORM_PULSE=12): assert `rst` at row 5 → all outputs 0 immediately; after release, the FSM stays in IDLE until a new request.
- **READ_OUT:** `re`=1, CE=0, 32 RE pulses of 40 ns period at 10 ns clk → `register_add` steps 0..31 then wraps to 0; `read_count_flag` is high for 1 cycle on the 32nd rise; `busy` falls the same cycle.
- **Fill then program** (`we`=1, WRITE_PULSE=4, DEPTH=32): 32 WE_L pulses → `cache_count_flag` pulses once, then PROGRAM runs.
  - Exactly 32 `pulse_en` pulses, each 4 cycles long with 1-cycle gaps.
  - `write_count_flag` arrives 160 cycles after the first `pulse_en`.
- **Non-power-of-two depth** (DEPTH=20, ADDR_W=5): READ_OUT wraps from 19 to 0 with the flag on the 20th rise; no address ≥20 ever appears.
- **Simultaneous requests:** `forming`=`we`=`re`=1 in IDLE → FORMING is entered. RE and WE_L toggling during FORMING leave `cache_add` at 0.
- **Abort:** CE driven to 1 at `cache_add`=7 in CACHE_FILL → next cycle IDLE, both counters 0, no `cache_count_flag`.

Source files
------------

// File: rtl/rram_seq_pkg.sv
// Shared state encoding and default sweep/pulse constants for the RRAM
// access sequencer.
package rram_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ_OUT,
      CACHE_FILL,
      PROGRAM,
      FORMING
   } seq_state_t;

   localparam int unsigned DEF_DEPTH       = 32;
   localparam int unsigned DEF_WRITE_PULSE = 4;
   localparam int unsigned DEF_FORM_PULSE  = 12;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for an asynchronous host strobe, followed by a
// rising-edge detector that yields a one-cycle pulse.
module strobe_sync (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= strobe;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;

endmodule

// File: rtl/rram_access_sequencer.sv
// Address and pulse sequencer for the RRAM macro: host read-out, cache fill,
// array program and forming sweeps with registered outputs.
module rram_access_sequencer
   import rram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned WRITE_PULSE = DEF_WRITE_PULSE,
   parameter int unsigned FORM_PULSE  = DEF_FORM_PULSE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              CE,
   input  logic              RE,
   input  logic              WE_L,
   input  logic              re,
   input  logic              we,
   input  logic              forming,
   output logic [ADDR_W-1:0] cache_add,
   output logic [ADDR_W-1:0] register_add,
   output logic              pulse_en,
   output logic              busy,
   output logic              read_count_flag,
   output logic              cache_count_flag,
   output logic              write_count_flag,
   output logic              forming_count_flag
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  WRITE_LAST = CNT_W'(WRITE_PULSE - 1);
   localparam logic [CNT_W-1:0]  FORM_LAST  = CNT_W'(FORM_PULSE - 1);

   seq_state_t        state, state_n;
   logic [ADDR_W-1:0] reg_add_n, cache_add_n;
   logic [CNT_W-1:0]  pulse_cnt, pulse_cnt_n, pulse_last;
   logic              started, started_n;
   logic              pulse_en_n;
   logic              read_flag_n, cache_flag_n, write_flag_n, form_flag_n;
   logic              re_rise, we_rise;

   strobe_sync u_re_sync (
      .clk    (clk),
      .rst    (rst),
      .strobe (RE),
      .rise   (re_rise)
   );

   strobe_sync u_we_sync (
      .clk    (clk),
      .rst    (rst),
      .strobe (WE_L),
      .rise   (we_rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         register_add       <= '0;
         cache_add          <= '0;
         pulse_cnt          <= '0;
         started            <= 1'b0;
         pulse_en           <= 1'b0;
         busy               <= 1'b0;
         read_count_flag    <= 1'b0;
         cache_count_flag   <= 1'b0;
         write_count_flag   <= 1'b0;
         forming_count_flag <= 1'b0;
      end else begin
         state              <= state_n;
         register_add       <= reg_add_n;
         cache_add          <= cache_add_n;
         pulse_cnt          <= pulse_cnt_n;
         started            <= started_n;
         pulse_en           <= pulse_en_n;
         busy               <= (state_n != IDLE);
         read_count_flag    <= read_flag_n;
         cache_count_flag   <= cache_flag_n;
         write_count_flag   <= write_flag_n;
         forming_count_flag <= form_flag_n;
      end
   end

   always_comb begin
      state_n      = state;
      reg_add_n    = register_add;
      cache_add_n  = cache_add;
      pulse_cnt_n  = pulse_cnt;
      started_n    = started;
      pulse_en_n   = pulse_en;
      read_flag_n  = 1'b0;
      cache_flag_n = 1'b0;
      write_flag_n = 1'b0;
      form_flag_n  = 1'b0;
      pulse_last   = (state == FORMING) ? FORM_LAST : WRITE_LAST;

      // Abort outranks any strobe or terminal count in the same cycle.
      if (state != IDLE && (!en || CE)) begin
         state_n     = IDLE;
         reg_add_n   = '0;
         cache_add_n = '0;
         pulse_cnt_n = '0;
         started_n   = 1'b0;
         pulse_en_n  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               reg_add_n   = '0;
               cache_add_n = '0;
               pulse_cnt_n = '0;
               started_n   = 1'b0;
               pulse_en_n  = 1'b0;
               if (en && !CE) begin
                  if (forming)  state_n = FORMING;
                  else if (we)  state_n = CACHE_FILL;
                  else if (re)  state_n = READ_OUT;
               end
            end
            READ_OUT: begin
               if (re_rise) begin
                  if (register_add == LAST_ADDR) begin
                     reg_add_n   = '0;
                     read_flag_n = 1'b1;
                     state_n     = IDLE;
                  end else begin
                     reg_add_n = register_add + ADDR_W'(1);
                  end
               end
            end
            CACHE_FILL: begin
               if (we_rise) begin
                  if (cache_add == LAST_ADDR) begin
                     cache_add_n  = '0;
                     cache_flag_n = 1'b1;
                     state_n      = PROGRAM;
                  end else begin
                     cache_add_n = cache_add + ADDR_W'(1);
                  end
               end
            end
            PROGRAM, FORMING: begin
               // started separates the lead-in cycle after entry from a row gap.
               if (pulse_en) begin
                  if (pulse_cnt == pulse_last) pulse_en_n  = 1'b0;
                  else                         pulse_cnt_n = pulse_cnt + CNT_W'(1);
               end else if (!started) begin
                  started_n   = 1'b1;
                  pulse_en_n  = 1'b1;
                  pulse_cnt_n = '0;
               end else if (register_add == LAST_ADDR) begin
                  state_n      = IDLE;
                  reg_add_n    = '0;
                  cache_add_n  = '0;
                  pulse_cnt_n  = '0;
                  started_n    = 1'b0;
                  write_flag_n = (state == PROGRAM);
                  form_flag_n  = (state == FORMING);
               end else begin
                  reg_add_n   = register_add + ADDR_W'(1);
                  if (state == PROGRAM) cache_add_n = cache_add + ADDR_W'(1);
                  pulse_en_n  = 1'b1;
                  pulse_cnt_n = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rram_access_sequencer.sv
// Scoreboard bench: expected output-change events (with cycle spacing) are
// queued by the stimulus and popped by a monitor whenever a DUT output moves.
module tb_rram_access_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en0 = 1'b0, en1 = 1'b0;
   logic CE = 1'b1, RE = 1'b0, WE_L = 1'b0;
   logic re = 1'b0, we = 1'b0, forming = 1'b0;

   logic [4:0] cache0, reg0, cache1, reg1;
   logic pe0, busy0, rf0, cf0, wf0, ff0;
   logic pe1, busy1, rf1, cf1, wf1, ff1;

   always #5 clk = ~clk;

   rram_access_sequencer #(
      .ADDR_W(5), .DEPTH(32), .CNT_W(4), .WRITE_PULSE(4), .FORM_PULSE(12)
   ) dut0 (
      .clk(clk), .rst(rst), .en(en0), .CE(CE), .RE(RE), .WE_L(WE_L),
      .re(re), .we(we), .forming(forming),
      .cache_add(cache0), .register_add(reg0), .pulse_en(pe0), .busy(busy0),
      .read_count_flag(rf0), .cache_count_flag(cf0),
      .write_count_flag(wf0), .forming_count_flag(ff0)
   );

   rram_access_sequencer #(
      .ADDR_W(5), .DEPTH(20), .CNT_W(4), .WRITE_PULSE(2), .FORM_PULSE(3)
   ) dut1 (
      .clk(clk), .rst(rst), .en(en1), .CE(CE), .RE(RE), .WE_L(WE_L),
      .re(re), .we(we), .forming(forming),
      .cache_add(cache1), .register_add(reg1), .pulse_en(pe1), .busy(busy1),
      .read_count_flag(rf1), .cache_count_flag(cf1),
      .write_count_flag(wf1), .forming_count_flag(ff1)
   );

   // snap = {busy, pulse_en, forming_flag, write_flag, cache_flag, read_flag, cache_add, register_add}
   typedef struct packed {
      logic        unit;
      logic [7:0]  delta;   // 0 = spacing not checked
      logic [15:0] snap;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;

   localparam logic [3:0] F_READ  = 4'b0001;
   localparam logic [3:0] F_CACHE = 4'b0010;
   localparam logic [3:0] F_WRITE = 4'b0100;
   localparam logic [3:0] F_FORM  = 4'b1000;

   task automatic push(input logic u, input int unsigned d, input logic b,
                       input logic pe, input logic [3:0] f,
                       input int unsigned c, input int unsigned r);
      exp_t e;
      e.unit  = u;
      e.delta = 8'(d);
      e.snap  = {b, pe, f, 5'(c), 5'(r)};
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic u, input int unsigned d, input logic [15:0] s);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event unit=%0d got snap=%h delta=%0d, required no event", u, s, d);
      end else begin
         e = exp_q.pop_front();
         if (e.unit !== u || e.snap !== s || (e.delta != 0 && int'(e.delta) != d)) begin
            errors++;
            $display("FAIL event unit=%0d got snap=%h delta=%0d, required unit=%0d snap=%h delta=%0d",
                     u, s, d, e.unit, e.snap, e.delta);
         end
      end
   endtask

   task automatic check_zero(input string name, input logic [15:0] s);
      checks++;
      if (s !== 16'h0) begin
         errors++;
         $display("FAIL %s got=%h required=0000", name, s);
      end
   endtask

   int unsigned cyc = 0, last0 = 0, last1 = 0;
   logic [15:0] prev0 = '0, prev1 = '0;

   always @(negedge clk) begin
      logic [15:0] s0, s1;
      cyc++;
      s0 = {busy0, pe0, ff0, wf0, cf0, rf0, cache0, reg0};
      s1 = {busy1, pe1, ff1, wf1, cf1, rf1, cache1, reg1};
      if (s0 !== prev0) begin
         observe(1'b0, cyc - last0, s0);
         prev0 = s0;
         last0 = cyc;
      end
      if (s1 !== prev1) begin
         observe(1'b1, cyc - last1, s1);
         prev1 = s1;
         last1 = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_pulse(input logic use_we);
      if (use_we) WE_L = 1'b1; else RE = 1'b1;
      tick();
      tick();
      WE_L = 1'b0;
      RE   = 1'b0;
      tick();
      tick();
   endtask

   task automatic drain(input string name, input int unsigned budget);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog expired, required completion");
      $fatal(1);
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      check_zero("reset_dut0", {busy0, pe0, ff0, wf0, cf0, rf0, cache0, reg0});
      check_zero("reset_dut1", {busy1, pe1, ff1, wf1, cf1, rf1, cache1, reg1});
      repeat (3) tick();
      rst = 1'b0;
      en0 = 1'b1;
      CE  = 1'b0;
      tick();

      // READ_OUT, DEPTH 32
      push(0, 0, 1, 0, 0, 0, 0);
      for (int unsigned k = 1; k < 32; k++) push(0, (k == 1) ? 3 : 4, 1, 0, 0, 0, k);
      push(0, 4, 0, 0, F_READ, 0, 0);
      push(0, 1, 0, 0, 0, 0, 0);
      re = 1'b1;
      tick();
      re = 1'b0;
      repeat (32) strobe_pulse(1'b0);
      drain("read_out", 50);

      // strobes in IDLE must not produce any output change
      repeat (3) begin
         strobe_pulse(1'b0);
         strobe_pulse(1'b1);
      end

      // CACHE_FILL then PROGRAM, WRITE_PULSE 4
      push(0, 0, 1, 0, 0, 0, 0);
      for (int unsigned k = 1; k < 32; k++) push(0, (k == 1) ? 3 : 4, 1, 0, 0, k, 0);
      push(0, 4, 1, 0, F_CACHE, 0, 0);
      for (int unsigned r = 0; r < 32; r++) begin
         push(0, 1, 1, 1, 0, r, r);
         push(0, 4, 1, 0, 0, r, r);
      end
      push(0, 1, 0, 0, F_WRITE, 0, 0);
      push(0, 1, 0, 0, 0, 0, 0);
      we = 1'b1;
      tick();
      we = 1'b0;
      repeat (32) strobe_pulse(1'b1);
      drain("fill_program", 400);

      // all requests at once -> FORMING; strobes toggle; reset at row 5
      push(0, 0, 1, 0, 0, 0, 0);
      push(0, 1, 1, 1, 0, 0, 0);
      push(0, 12, 1, 0, 0, 0, 0);
      for (int unsigned r = 1; r <= 5; r++) begin
         push(0, 1, 1, 1, 0, 0, r);
         if (r < 5) push(0, 12, 1, 0, 0, 0, r);
      end
      push(0, 3, 0, 0, 0, 0, 0);
      forming = 1'b1;
      we      = 1'b1;
      re      = 1'b1;
      tick();
      forming = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
      for (int i = 0; i < 69; i++) begin
         tick();
         if (i % 2 == 1) begin
            RE   = ~RE;
            WE_L = ~WE_L;
         end
      end
      #2 rst = 1'b1;
      #1;
      check_zero("reset_mid_forming", {busy0, pe0, ff0, wf0, cf0, rf0, cache0, reg0});
      RE   = 1'b0;
      WE_L = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      drain("forming_reset", 20);

      // abort by CE at cache_add = 7
      push(0, 0, 1, 0, 0, 0, 0);
      for (int unsigned k = 1; k <= 7; k++) push(0, (k == 1) ? 3 : 4, 1, 0, 0, k, 0);
      push(0, 1, 0, 0, 0, 0, 0);
      we = 1'b1;
      tick();
      we = 1'b0;
      repeat (6) strobe_pulse(1'b1);
      WE_L = 1'b1;
      tick();
      tick();
      WE_L = 1'b0;
      tick();
      CE = 1'b1;
      tick();
      CE = 1'b0;
      repeat (5) tick();
      drain("abort", 20);

      // READ_OUT on the DEPTH 20 instance
      en0 = 1'b0;
      en1 = 1'b1;
      push(1, 0, 1, 0, 0, 0, 0);
      for (int unsigned k = 1; k < 20; k++) push(1, (k == 1) ? 3 : 4, 1, 0, 0, 0, k);
      push(1, 4, 0, 0, F_READ, 0, 0);
      push(1, 1, 0, 0, 0, 0, 0);
      re = 1'b1;
      tick();
      re = 1'b0;
      repeat (20) strobe_pulse(1'b0);
      drain("depth20", 50);

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
